// File: rtl/dmem_ctrl_pkg.sv
// Shared opcode encodings, state/request types and lane helpers for dmem_ctrl.
package dmem_ctrl_pkg;

  localparam int LSQ_OP_WIDTH = 4;

  localparam logic [LSQ_OP_WIDTH-1:0] OP_LB  = 4'd1;
  localparam logic [LSQ_OP_WIDTH-1:0] OP_LH  = 4'd2;
  localparam logic [LSQ_OP_WIDTH-1:0] OP_LW  = 4'd3;
  localparam logic [LSQ_OP_WIDTH-1:0] OP_LBU = 4'd4;
  localparam logic [LSQ_OP_WIDTH-1:0] OP_LHU = 4'd5;
  localparam logic [LSQ_OP_WIDTH-1:0] OP_SB  = 4'd9;
  localparam logic [LSQ_OP_WIDTH-1:0] OP_SH  = 4'd10;
  localparam logic [LSQ_OP_WIDTH-1:0] OP_SW  = 4'd11;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [LSQ_OP_WIDTH-1:0] op;
    logic [31:0]             addr;
    logic [31:0]             data;
  } req_t;

  // Unknown nonzero opcodes behave as a full word access of their direction.
  function automatic logic [LSQ_OP_WIDTH-1:0] op_norm(input logic [LSQ_OP_WIDTH-1:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: op_norm = op;
      default: op_norm = op[3] ? OP_SW : OP_LW;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [LSQ_OP_WIDTH-1:0] op,
                                          input logic [1:0] lo);
    case (op)
      OP_SB:   store_be = 4'b0001 << lo;
      OP_SH:   store_be = lo[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [LSQ_OP_WIDTH-1:0] op,
                                             input logic [31:0] d);
    case (op)
      OP_SB:   store_data = {4{d[7:0]}};
      OP_SH:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  function automatic logic [31:0] load_fmt(input logic [LSQ_OP_WIDTH-1:0] op,
                                           input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (op)
      OP_LB:   load_fmt = {{24{b[7]}}, b};
      OP_LBU:  load_fmt = {24'h0, b};
      OP_LH:   load_fmt = {{16{h[15]}}, h};
      OP_LHU:  load_fmt = {16'h0, h};
      default: load_fmt = w;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ctrl_array.sv
// Single-port synchronous data array, 32-bit words with byte enables (module dmem_array).
module dmem_array #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned i = 0; i < 4; i++)
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Fixed-latency data memory controller with a one-entry pending slot.
// Optional DMEM_MISALIGN_EN: flag misaligned accesses instead of force-aligning them.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int LATENCY    = 2,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LSQ_OP_WIDTH-1:0] Op_in,
  input  logic [31:0]             Addr_in,
  input  logic [31:0]             wr_data_in,
  output logic                    mem_rd_ready,
  output logic [31:0]             mem_rd_data,
  output logic                    mem_wr_ready,
  output logic                    busy,
  output logic                    misalign,
  output logic                    overflow
);

  state_t                  state, state_nx;
  logic [3:0]              cnt, cnt_nx;
  req_t                    cur, cur_nx, pend, pend_nx, in_req, start_req;
  logic                    pend_v, pend_v_nx;
  logic                    req_valid, start, ovf_set, acc, mis;
  logic [LSQ_OP_WIDTH-1:0] in_op;
  logic [31:0]             in_addr, rdata;

  assign req_valid = (Op_in != '0);
  assign in_op     = op_norm(Op_in);
  assign in_req    = '{op: in_op, addr: in_addr, data: wr_data_in};

`ifdef DMEM_MISALIGN_EN
  assign in_addr = Addr_in;

  always_comb begin
    case (cur_nx.op)
      OP_LH, OP_LHU, OP_SH: mis = cur_nx.addr[0];
      OP_LW, OP_SW:         mis = |cur_nx.addr[1:0];
      default:              mis = 1'b0;
    endcase
  end
`else
  always_comb begin
    in_addr = Addr_in;
    case (in_op)
      OP_LH, OP_LHU, OP_SH: in_addr[0]   = 1'b0;
      OP_LW, OP_SW:         in_addr[1:0] = '0;
      default: ;
    endcase
  end

  assign mis = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    cur_nx    = cur;
    pend_nx   = pend;
    pend_v_nx = pend_v;
    ovf_set   = 1'b0;
    start     = 1'b0;
    start_req = in_req;
    case (state)
      IDLE: start = req_valid;
      WAIT: begin
        if (cnt == 4'd1) state_nx = RESP;
        else             cnt_nx   = cnt - 4'd1;
        if (req_valid) begin
          if (pend_v) ovf_set = 1'b1;
          else begin
            pend_nx   = in_req;
            pend_v_nx = 1'b1;
          end
        end
      end
      RESP: begin
        state_nx = IDLE;
        // An arrival in RESP with the slot empty is serviced directly; with it full, dropped.
        if (pend_v) begin
          start     = 1'b1;
          start_req = pend;
          pend_v_nx = 1'b0;
          ovf_set   = req_valid;
        end else begin
          start = req_valid;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (start) begin
      cur_nx = start_req;
      if (LATENCY == 1) state_nx = RESP;
      else begin
        state_nx = WAIT;
        cnt_nx   = 4'(LATENCY - 1);
      end
    end
  end

  // The array is accessed on the edge that enters RESP, so ready and data land together.
  assign acc = (state_nx == RESP) && !rst;

  dmem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .en    (acc && !mis),
    .we    (cur_nx.op[3]),
    .be    (store_be(cur_nx.op, cur_nx.addr[1:0])),
    .idx   (cur_nx.addr[DEPTH_LOG2+1:2]),
    .wdata (store_data(cur_nx.op, cur_nx.data)),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      cur          <= '0;
      pend         <= '0;
      pend_v       <= 1'b0;
      mem_rd_ready <= 1'b0;
      mem_wr_ready <= 1'b0;
      busy         <= 1'b0;
      misalign     <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      cur          <= cur_nx;
      pend         <= pend_nx;
      pend_v       <= pend_v_nx;
      mem_rd_ready <= acc && !cur_nx.op[3];
      mem_wr_ready <= acc && cur_nx.op[3];
      busy         <= (state_nx != IDLE);
      misalign     <= acc && mis;
      overflow     <= overflow | ovf_set;
    end
  end

  // Lane extraction works on the registered array word and registered request only.
  assign mem_rd_data = (mem_rd_ready && !misalign) ? load_fmt(cur.op, cur.addr[1:0], rdata) : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized self-checking bench for dmem_ctrl against a transaction-level model.
module tb_dmem_ctrl;

  localparam int LAT = 2;
  localparam int DL2 = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  Op_in;
  logic [31:0] Addr_in, wr_data_in;
  logic        mem_rd_ready, mem_wr_ready, busy, misalign, overflow;
  logic [31:0] mem_rd_data;

  dmem_ctrl #(.LATENCY(LAT), .DEPTH_LOG2(DL2)) dut (
    .clk          (clk),
    .rst          (rst),
    .Op_in        (Op_in),
    .Addr_in      (Addr_in),
    .wr_data_in   (wr_data_in),
    .mem_rd_ready (mem_rd_ready),
    .mem_rd_data  (mem_rd_data),
    .mem_wr_ready (mem_wr_ready),
    .busy         (busy),
    .misalign     (misalign),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          rdy;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t       q[$];
  logic [7:0] mm [4096];
  bit         ovf;
  int         cyc;
  int         n_tests;
  int         n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [3:0] norm(input logic [3:0] op);
    if (op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd11}) return op;
    return op[3] ? 4'd11 : 4'd3;
  endfunction

  task automatic complete(input ent_t e, output logic rd, output logic wr,
                          output logic mis, output logic [31:0] data);
    logic [3:0]  op;
    logic [31:0] v;
    int          sz, a;
    op   = norm(e.op);
    sz   = (op inside {4'd1, 4'd4, 4'd9}) ? 1 : (op inside {4'd2, 4'd5, 4'd10}) ? 2 : 4;
    a    = int'(e.addr[DL2+1:0]);
    rd   = !op[3];
    wr   = op[3];
    mis  = 1'b0;
    data = '0;
`ifdef DMEM_MISALIGN_EN
    mis = (a % sz) != 0;
`else
    a = a - (a % sz);
`endif
    if (!mis) begin
      if (op[3]) begin
        for (int k = 0; k < sz; k++) mm[a+k] = e.data[8*k +: 8];
      end else begin
        v = '0;
        for (int k = 0; k < sz; k++) v[8*k +: 8] = mm[a+k];
        if (op == 4'd1 && v[7])  v[31:8]  = '1;
        if (op == 4'd2 && v[15]) v[31:16] = '1;
        data = v;
      end
    end
  endtask

  task automatic check_cycle();
    logic        erd, ewr, emis, ebusy;
    logic [31:0] edata;
    ent_t        e;
    erd = 1'b0; ewr = 1'b0; emis = 1'b0; edata = '0;
    ebusy = (q.size() > 0) && (q[0].rdy - LAT < cyc);
    if (q.size() > 0 && q[0].rdy == cyc) begin
      e = q.pop_front();
      complete(e, erd, ewr, emis, edata);
    end
    check("rd_ready", 32'(mem_rd_ready), 32'(erd));
    check("wr_ready", 32'(mem_wr_ready), 32'(ewr));
    check("rd_data",  mem_rd_data,       edata);
    check("busy",     32'(busy),         32'(ebusy));
    check("misalign", 32'(misalign),     32'(emis));
    check("overflow", 32'(overflow),     32'(ovf));
  endtask

  task automatic update(input bit r, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] d);
    ent_t e;
    bit   full;
    if (r) begin
      q.delete();
      ovf = 1'b0;
    end else if (op != 4'd0) begin
      full = 1'b0;
      foreach (q[i]) if (q[i].rdy - LAT >= cyc) full = 1'b1;
      if (full) ovf = 1'b1;
      else begin
        e.rdy  = (q.size() == 0) ? cyc + LAT : q[q.size()-1].rdy + LAT;
        e.op   = op;
        e.addr = a;
        e.data = d;
        q.push_back(e);
      end
    end
  endtask

  task automatic step(input bit r, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] d);
    @(posedge clk);
    #1;
    rst = r; Op_in = op; Addr_in = a; wr_data_in = d;
    cyc++;
    @(negedge clk);
    check_cycle();
    update(r, op, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, '0, '0);
  endtask

  function automatic logic [31:0] win_addr(input int unsigned w, input logic [1:0] lo);
    logic [9:0] idx;
    idx = (w < 8) ? 10'(w) : 10'(1008 + w);
    return {20'($urandom), idx, lo};
  endfunction

  localparam logic [3:0] OPS [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd10,
                                      4'd11, 4'd6, 4'd14, 4'd8, 4'd15};
`ifdef DMEM_MISALIGN_EN
  localparam logic [31:0] MIS_BIT  = 32'd1;
  localparam logic [31:0] MIS_WORD = 32'h80ADBEEF;
`else
  localparam logic [31:0] MIS_BIT  = 32'd0;
  localparam logic [31:0] MIS_WORD = 32'hCAFEF00D;
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog cycle=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    n_tests = 0; n_fail = 0; cyc = 0; ovf = 1'b0;
    rst = 1'b1; Op_in = '0; Addr_in = '0; wr_data_in = '0;
    step(1'b1, 4'd0, '0, '0);
    step(1'b1, 4'd0, '0, '0);
    check("reset_busy",     32'(busy),         32'd0);
    check("reset_wr_ready", 32'(mem_wr_ready), 32'd0);
    check("reset_overflow", 32'(overflow),     32'd0);
    idle(1);

    for (int unsigned w = 0; w < 16; w++) begin
      step(1'b0, 4'd11, win_addr(w, 2'b00), $urandom);
      idle(1);
    end
    idle(2);

    step(1'b0, 4'd11, 32'h10, 32'hDEADBEEF);
    idle(1);
    check("sw_not_early", 32'(mem_wr_ready), 32'd0);
    idle(1);
    check("sw_wr_ready", 32'(mem_wr_ready), 32'd1);

    step(1'b0, 4'd3, 32'h10, '0);
    idle(2);
    check("lw_rd_ready", 32'(mem_rd_ready), 32'd1);
    check("lw_data",     mem_rd_data,       32'hDEADBEEF);

    step(1'b0, 4'd9, 32'h13, 32'h80);  idle(2);
    step(1'b0, 4'd1, 32'h13, '0);      idle(2);
    check("lb_sext", mem_rd_data, 32'hFFFFFF80);
    step(1'b0, 4'd4, 32'h13, '0);      idle(2);
    check("lbu_zext", mem_rd_data, 32'h00000080);
    step(1'b0, 4'd2, 32'h12, '0);      idle(2);
    check("lh_sext", mem_rd_data, 32'hFFFF80AD);

    step(1'b0, 4'd3, 32'h10, '0);
    step(1'b0, 4'd3, 32'h10, '0);
    step(1'b0, 4'd3, 32'h10, '0);
    check("b2b_first", 32'(mem_rd_ready), 32'd1);
    idle(1);
    check("b2b_overflow", 32'(overflow),     32'd1);
    check("b2b_gap",      32'(mem_rd_ready), 32'd0);
    idle(1);
    check("b2b_pending", 32'(mem_rd_ready), 32'd1);
    check("b2b_data",    mem_rd_data,       32'h80ADBEEF);
    idle(3);

    step(1'b0, 4'd11, 32'h10, 32'h12345678);
    step(1'b1, 4'd0, '0, '0);
    step(1'b0, 4'd0, '0, '0);
    check("rst_mid_busy",  32'(busy),         32'd0);
    check("rst_mid_wr",    32'(mem_wr_ready), 32'd0);
    check("rst_mid_ovf",   32'(overflow),     32'd0);
    idle(1);
    step(1'b0, 4'd3, 32'h10, '0);      idle(2);
    check("rst_mid_mem", mem_rd_data, 32'h80ADBEEF);

    step(1'b0, 4'd11, 32'h11, 32'hCAFEF00D); idle(2);
    check("mis_wr_ready", 32'(mem_wr_ready), 32'd1);
    check("mis_flag",     32'(misalign),     MIS_BIT);
    step(1'b0, 4'd3, 32'h10, '0);      idle(2);
    check("mis_word", mem_rd_data, MIS_WORD);

    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2)       step(1'b1, 4'd0, '0, '0);
      else if (r < 55) step(1'b0, OPS[$urandom_range(0, 11)],
                            win_addr($urandom_range(0, 15), 2'($urandom)), $urandom);
      else             step(1'b0, 4'd0, '0, '0);
    end
    idle(LAT + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
